// File: rtl/l2_axi_responder_pkg.sv
// l2_axi_responder_pkg: widths, AXI burst/response codes, FSM state type and burst check shared by the responder
package l2_axi_responder_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int ID_W = 4;
  localparam int MEM_AW = 16;
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W = $clog2(STRB_W);
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_e;
  function automatic logic burst_ok(input logic [1:0] b);
    return b == BURST_INCR || b == BURST_FIXED;
  endfunction
endpackage

// File: rtl/l2_axi_responder_fifo.sv
// l2_axi_responder_fifo: 2-entry read-return FIFO; ports clk_i/rst_ni, push/wdata in, pop in, rdata/empty/fill out
module l2_axi_responder_fifo #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic [1:0]   fill
);
  logic [W-1:0] mem [2];
  logic wp, rp;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem <= '{default: '0};
      wp <= 1'b0;
      rp <= 1'b0;
      fill <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= wdata;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      fill <= fill + {1'b0, push} - {1'b0, pop};
    end
  end
  assign rdata = mem[rp];
  assign empty = fill == 2'd0;
endmodule

// File: rtl/l2_axi_responder.sv
// l2_axi_responder: AXI4 burst slave onto a 1-cycle SRAM; ports clk_i/rst_ni, AW/W/B/AR/R channels, mem_* SRAM port
module l2_axi_responder
  import l2_axi_responder_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              aw_valid_i,
  output logic              aw_ready_o,
  input  logic [ID_W-1:0]   aw_id_i,
  input  logic [ADDR_W-1:0] aw_addr_i,
  input  logic [7:0]        aw_len_i,
  input  logic [2:0]        aw_size_i,
  input  logic [1:0]        aw_burst_i,
  input  logic              w_valid_i,
  output logic              w_ready_o,
  input  logic [DATA_W-1:0] w_data_i,
  input  logic [STRB_W-1:0] w_strb_i,
  input  logic              w_last_i,
  output logic              b_valid_o,
  input  logic              b_ready_i,
  output logic [ID_W-1:0]   b_id_o,
  output logic [1:0]        b_resp_o,
  output logic              b_user_o,
  input  logic              ar_valid_i,
  output logic              ar_ready_o,
  input  logic [ID_W-1:0]   ar_id_i,
  input  logic [ADDR_W-1:0] ar_addr_i,
  input  logic [7:0]        ar_len_i,
  input  logic [2:0]        ar_size_i,
  input  logic [1:0]        ar_burst_i,
  output logic              r_valid_o,
  input  logic              r_ready_i,
  output logic [ID_W-1:0]   r_id_o,
  output logic [DATA_W-1:0] r_data_o,
  output logic [1:0]        r_resp_o,
  output logic              r_last_o,
  output logic              r_user_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [STRB_W-1:0] mem_be_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  state_e state, state_n;
  logic last_wr, pick_rd, take_aw, take_ar, w_hs, rd_issue, pop, empty, ok, at_end;
  logic pend_v, pend_last, pend_err;
  logic [ID_W-1:0] id_q, pend_id;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0] len_q;
  logic [2:0] size_q;
  logic [1:0] burst_q, bresp_q, fill;
  logic [8:0] cnt;
  logic [DATA_W-1:0] push_data;
  logic [ID_W+DATA_W+2:0] head;
  // pend_* is the read issued last cycle whose SRAM data arrives now; credit counts it alongside the FIFO fill
  always_comb begin
    pick_rd = ar_valid_i && (!aw_valid_i || last_wr);
    take_ar = rst_ni && state == IDLE && pick_rd;
    take_aw = rst_ni && state == IDLE && aw_valid_i && !pick_rd;
    ok = burst_ok(burst_q);
    at_end = cnt == {1'b0, len_q};
    pop = r_valid_o && r_ready_i;
    w_hs = state == WRITE && w_valid_i;
    rd_issue = state == READ && ({1'b0, fill} + {2'b0, pend_v}) < (3'd2 + {2'b0, pop});
    state_n = take_ar ? READ : take_aw ? WRITE : (w_hs && w_last_i) ? WRESP :
              ((state == WRESP && b_ready_i) || (rd_issue && at_end)) ? IDLE : state;
    aw_ready_o = take_aw;
    ar_ready_o = take_ar;
    w_ready_o = state == WRITE;
    b_valid_o = state == WRESP;
    mem_req_o = (w_hs || rd_issue) && ok;
    mem_we_o = w_hs && ok;
    mem_addr_o = addr_q[OFF_W +: MEM_AW];
    mem_wdata_o = mem_we_o ? w_data_i : '0;
    mem_be_o = mem_we_o ? w_strb_i : '0;
    push_data = pend_err ? '0 : mem_rdata_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      last_wr <= 1'b1;
      id_q <= '0;
      addr_q <= '0;
      len_q <= '0;
      size_q <= '0;
      burst_q <= '0;
      bresp_q <= '0;
      cnt <= '0;
      pend_v <= 1'b0;
      pend_last <= 1'b0;
      pend_err <= 1'b0;
      pend_id <= '0;
    end else begin
      state <= state_n;
      pend_v <= rd_issue;
      pend_last <= at_end;
      pend_err <= !ok;
      pend_id <= id_q;
      if (take_aw || take_ar) begin
        last_wr <= take_aw;
        id_q <= take_aw ? aw_id_i : ar_id_i;
        addr_q <= take_aw ? aw_addr_i : ar_addr_i;
        len_q <= take_aw ? aw_len_i : ar_len_i;
        size_q <= take_aw ? aw_size_i : ar_size_i;
        burst_q <= take_aw ? aw_burst_i : ar_burst_i;
        cnt <= '0;
      end else if (w_hs || rd_issue) begin
        cnt <= cnt + 9'd1;
        if (burst_q == BURST_INCR) addr_q <= addr_q + (ADDR_W'(1) << size_q);
      end
      if (w_hs && w_last_i) bresp_q <= (ok && at_end) ? RESP_OKAY : RESP_SLVERR;
    end
  end
  l2_axi_responder_fifo #(.W(ID_W + DATA_W + 3)) u_fifo (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .push(pend_v),
    .pop(pop),
    .wdata({pend_id, push_data, pend_err ? RESP_SLVERR : RESP_OKAY, pend_last}),
    .rdata(head),
    .empty(empty),
    .fill(fill)
  );
  assign {r_id_o, r_data_o, r_resp_o, r_last_o} = head;
  assign r_valid_o = !empty;
  assign b_id_o = id_q;
  assign b_resp_o = bresp_q;
  assign b_user_o = 1'b0;
  assign r_user_o = 1'b0;
endmodule

// File: tb/tb_l2_axi_responder.sv
// tb_l2_axi_responder: directed vector bench for l2_axi_responder with a behavioural 1-cycle SRAM
module tb_l2_axi_responder;
  import l2_axi_responder_pkg::*;
  logic clk = 1'b0, rst_ni = 1'b0;
  logic aw_valid = 0, aw_ready, w_valid = 0, w_ready, w_last = 0, b_valid, b_ready = 1, b_user;
  logic ar_valid = 0, ar_ready, r_valid, r_ready = 1, r_last, r_user;
  logic [3:0] aw_id = 0, ar_id = 0, b_id, r_id;
  logic [31:0] aw_addr = 0, ar_addr = 0;
  logic [7:0] aw_len = 0, ar_len = 0, w_strb = 0, mem_be;
  logic [2:0] aw_size = 3, ar_size = 3;
  logic [1:0] aw_burst = 1, ar_burst = 1, b_resp, r_resp;
  logic [63:0] w_data = 0, r_data, mem_wdata, mem_rdata = 0;
  logic mem_req, mem_we;
  logic [15:0] mem_addr;
  int nvec = 0, nmis = 0;
  typedef struct {
    logic arv;
    logic exp_arr;
    logic exp_req;
    logic [15:0] exp_addr;
    logic exp_rv;
    logic [15:0] exp_d;
    logic exp_last;
  } vec_t;
  vec_t tbl [8];
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_req && !mem_we) mem_rdata <= {48'hCAFE_0000_0000, mem_addr};
  l2_axi_responder dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id), .aw_addr_i(aw_addr),
    .aw_len_i(aw_len), .aw_size_i(aw_size), .aw_burst_i(aw_burst),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last),
    .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp), .b_user_o(b_user),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_addr_i(ar_addr),
    .ar_len_i(ar_len), .ar_size_i(ar_size), .ar_burst_i(ar_burst),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data), .r_resp_o(r_resp),
    .r_last_o(r_last), .r_user_o(r_user),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
  );
  function automatic logic [63:0] rd_word(input logic [15:0] a);
    return {48'hCAFE_0000_0000, a};
  endfunction
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic timeout(input string nm);
    nvec++;
    nmis++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask
  task automatic ar_hs(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bu, input logic [3:0] id);
    int k = 0;
    ar_valid = 1; ar_addr = a; ar_len = l; ar_size = 3; ar_burst = bu; ar_id = id;
    @(negedge clk);
    while (!ar_ready && k < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      k++;
    end
    if (!ar_ready) timeout("ar_handshake");
    @(posedge clk); #1;
    ar_valid = 0;
  endtask
  task automatic aw_hs(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bu, input logic [3:0] id);
    int k = 0;
    aw_valid = 1; aw_addr = a; aw_len = l; aw_size = 3; aw_burst = bu; aw_id = id;
    @(negedge clk);
    while (!aw_ready && k < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      k++;
    end
    if (!aw_ready) timeout("aw_handshake");
    @(posedge clk); #1;
    aw_valid = 0;
  endtask
  task automatic read_burst(input string nm, input logic [31:0] a, input logic [7:0] l, input logic [1:0] bu,
                            input bit toggle, input bit err, input logic [3:0] id);
    int beats = 0, issued = 0, popped = 0, maxo = 0;
    logic [15:0] wa;
    wa = a[18:3];
    ar_hs(a, l, bu, id);
    for (int c = 0; c < 200 && beats <= int'(l); c++) begin
      r_ready = !toggle || (c % 2 == 0);
      @(negedge clk);
      if (mem_req && !mem_we) issued++;
      if (r_valid && r_ready) begin
        check($sformatf("%s_data%0d", nm, beats), r_data, err ? 64'h0 : rd_word(wa + 16'(beats)));
        check($sformatf("%s_resp%0d", nm, beats), r_resp, err ? RESP_SLVERR : RESP_OKAY);
        check($sformatf("%s_last%0d", nm, beats), r_last, beats == int'(l));
        check($sformatf("%s_id%0d", nm, beats), r_id, id);
        popped++;
        beats++;
      end
      if (issued - popped > maxo) maxo = issued - popped;
      @(posedge clk); #1;
    end
    r_ready = 1;
    check({nm, "_beats"}, beats, int'(l) + 1);
    check({nm, "_memreads"}, issued, err ? 0 : int'(l) + 1);
    nvec++;
    if (maxo > 2) begin
      nmis++;
      $display("FAIL %s_outstanding: got %0d required at most 2", nm, maxo);
    end
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check({nm, "_no_extra"}, r_valid, 0);
    @(posedge clk); #1;
  endtask
  task automatic write_burst(input string nm, input logic [31:0] a, input logic [7:0] l, input logic [1:0] bu,
                             input int nb, input logic [1:0] exp_resp);
    logic [15:0] wa;
    wa = a[18:3];
    aw_hs(a, l, bu, 4'h5);
    for (int i = 0; i < nb; i++) begin
      w_valid = 1;
      w_data = 64'h1111_2222_3333_0000 | 64'(i);
      w_strb = (i % 2 == 1) ? 8'hF0 : 8'h0F;
      w_last = i == nb - 1;
      @(negedge clk);
      check($sformatf("%s_wready%0d", nm, i), w_ready, 1);
      check($sformatf("%s_req%0d", nm, i), mem_req, bu == BURST_INCR);
      if (bu == BURST_INCR) begin
        check($sformatf("%s_we%0d", nm, i), mem_we, 1);
        check($sformatf("%s_addr%0d", nm, i), mem_addr, wa + 16'(i));
        check($sformatf("%s_be%0d", nm, i), mem_be, w_strb);
        check($sformatf("%s_wdata%0d", nm, i), mem_wdata, w_data);
      end
      @(posedge clk); #1;
    end
    w_valid = 0; w_last = 0;
    @(negedge clk);
    check({nm, "_bvalid"}, b_valid, 1);
    check({nm, "_bresp"}, b_resp, exp_resp);
    check({nm, "_bid"}, b_id, 4'h5);
    @(posedge clk); #1;
    @(negedge clk);
    check({nm, "_bdone"}, b_valid, 0);
    @(posedge clk); #1;
  endtask
  task automatic arb_round(input int r, input bit exp_rd);
    int k = 0;
    logic got_rd, got_wr;
    aw_valid = 1; aw_addr = 32'h800; aw_len = 0; aw_burst = BURST_INCR; aw_id = 4'h1;
    ar_valid = 1; ar_addr = 32'h900; ar_len = 0; ar_burst = BURST_INCR; ar_id = 4'h2;
    @(negedge clk);
    got_rd = ar_ready;
    got_wr = aw_ready;
    check($sformatf("arb%0d_ar_ready", r), got_rd, exp_rd);
    check($sformatf("arb%0d_aw_ready", r), got_wr, !exp_rd);
    @(posedge clk); #1;
    aw_valid = 0; ar_valid = 0;
    if (got_rd) begin
      @(negedge clk);
      while (!r_valid && k < 10) begin
        @(posedge clk); #1;
        @(negedge clk);
        k++;
      end
      if (!r_valid) timeout("arb_read");
      @(posedge clk); #1;
    end else if (got_wr) begin
      w_valid = 1; w_last = 1; w_strb = 8'hFF; w_data = 64'h77;
      @(negedge clk);
      @(posedge clk); #1;
      w_valid = 0; w_last = 0;
      @(negedge clk);
      while (!b_valid && k < 10) begin
        @(posedge clk); #1;
        @(negedge clk);
        k++;
      end
      if (!b_valid) timeout("arb_write");
      @(posedge clk); #1;
    end
  endtask
  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 16'h00, 1'b0, 16'h00, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 16'h20, 1'b0, 16'h00, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 16'h21, 1'b0, 16'h00, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 16'h22, 1'b1, 16'h20, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 16'h23, 1'b1, 16'h21, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 16'h00, 1'b1, 16'h22, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 16'h00, 1'b1, 16'h23, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 16'h00, 1'b0, 16'h00, 1'b0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_aw_ready", aw_ready, 0);
    check("rst_ar_ready", ar_ready, 0);
    check("rst_w_ready", w_ready, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    @(posedge clk); #1;
    rst_ni = 1;
    @(posedge clk); #1;
    arb_round(0, 1);
    arb_round(1, 0);
    arb_round(2, 1);
    arb_round(3, 0);
    ar_addr = 32'h100; ar_len = 3; ar_size = 3; ar_burst = BURST_INCR; ar_id = 4'h3; r_ready = 1;
    for (int i = 0; i < 8; i++) begin
      ar_valid = tbl[i].arv;
      @(negedge clk);
      check($sformatf("tbl%0d_ar_ready", i), ar_ready, tbl[i].exp_arr);
      check($sformatf("tbl%0d_mem_req", i), mem_req, tbl[i].exp_req);
      if (tbl[i].exp_req) check($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].exp_addr);
      check($sformatf("tbl%0d_r_valid", i), r_valid, tbl[i].exp_rv);
      if (tbl[i].exp_rv) begin
        check($sformatf("tbl%0d_r_data", i), r_data, rd_word(tbl[i].exp_d));
        check($sformatf("tbl%0d_r_last", i), r_last, tbl[i].exp_last);
        check($sformatf("tbl%0d_r_resp", i), r_resp, RESP_OKAY);
        check($sformatf("tbl%0d_r_id", i), r_id, 4'h3);
      end
      @(posedge clk); #1;
    end
    ar_valid = 0;
    write_burst("wr_incr", 32'h40, 8'd1, BURST_INCR, 2, RESP_OKAY);
    read_burst("rd_toggle", 32'h200, 8'd7, BURST_INCR, 1, 0, 4'h4);
    read_burst("rd_wrap", 32'h300, 8'd3, BURST_WRAP, 0, 1, 4'h8);
    write_burst("wr_short", 32'h600, 8'd3, BURST_INCR, 2, RESP_SLVERR);
    write_burst("wr_wrap", 32'h700, 8'd0, BURST_WRAP, 1, RESP_SLVERR);
    r_ready = 0;
    ar_valid = 1; ar_addr = 32'h400; ar_len = 7; ar_size = 3; ar_burst = BURST_INCR; ar_id = 4'h6;
    @(negedge clk);
    check("rst_mid_ar_ready", ar_ready, 1);
    @(posedge clk); #1;
    ar_valid = 0;
    @(negedge clk);
    check("rst_mid_beat1_req", mem_req, 1);
    check("rst_mid_beat1_addr", mem_addr, 16'h80);
    @(posedge clk); #1;
    rst_ni = 0;
    ar_valid = 1;
    @(negedge clk);
    check("rst_mid_mem_req", mem_req, 0);
    check("rst_mid_r_valid", r_valid, 0);
    check("rst_mid_ar_ready", ar_ready, 0);
    check("rst_mid_mem_addr", mem_addr, 0);
    check("rst_mid_w_ready", w_ready, 0);
    @(posedge clk); #1;
    rst_ni = 1; ar_valid = 0; r_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_abandoned", r_valid, 0);
    @(posedge clk); #1;
    read_burst("rd_after_rst", 32'h500, 8'd0, BURST_INCR, 0, 0, 4'h7);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
